// File: rtl/usb_port_sig_tx.sv
`timescale 1ns/1ps
// Root-port bus-signaling generator: drives port reset SE0, resume K + EOP and
// low-speed keep-alive EOP onto the transceiver, and pulses DONE on completion.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | transceiver released, waiting for a request
// S_RESET   | port reset, SE0 for RST_CYC cycles
// S_RESUME  | host resume, K for RESM_CYC cycles
// S_EOP_SE0 | EOP first part, SE0 for two low-speed bit times
// S_EOP_J   | EOP final part, J for one low-speed bit time
module usb_port_sig_tx #(
  parameter int RST_CYC  = 120000,
  parameter int RESM_CYC = 240000,
  parameter int EOP_BIT  = 8
) (
  input  logic clk_12m,
  input  logic rst,
  input  logic start_rst,
  input  logic start_resm,
  input  logic sofgen,
  input  logic lsdev,
  input  logic enable,
  output logic txe,
  output logic txdp,
  output logic txdn,
  output logic busy,
  output logic done
);

  localparam int MAX_A   = (RST_CYC > RESM_CYC) ? RST_CYC : RESM_CYC;
  localparam int MAX_CYC = (MAX_A > 2 * EOP_BIT) ? MAX_A : 2 * EOP_BIT;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] RESM_LOAD = CNT_W'(RESM_CYC - 1);
  localparam logic [CNT_W-1:0] SE0_LOAD  = CNT_W'(2 * EOP_BIT - 1);
  localparam logic [CNT_W-1:0] J_LOAD    = CNT_W'(EOP_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RESUME,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lsp;

  // K drives DP=lsp/DN=~lsp, J the complement; outputs follow the state being entered.
  always_ff @(posedge clk_12m or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      lsp   <= 1'b0;
      txe   <= 1'b0;
      txdp  <= 1'b0;
      txdn  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_rst && state != S_RESET) begin
        if (state == S_IDLE) lsp <= lsdev;
        state <= S_RESET;
        cnt   <= RST_LOAD;
        txe   <= 1'b1;
        txdp  <= 1'b0;
        txdn  <= 1'b0;
        busy  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_resm) begin
              state <= S_RESUME;
              cnt   <= RESM_LOAD;
              lsp   <= lsdev;
              txe   <= 1'b1;
              txdp  <= lsdev;
              txdn  <= ~lsdev;
              busy  <= 1'b1;
            end else if (sofgen && enable && lsdev) begin
              state <= S_EOP_SE0;
              cnt   <= SE0_LOAD;
              lsp   <= lsdev;
              txe   <= 1'b1;
              txdp  <= 1'b0;
              txdn  <= 1'b0;
              busy  <= 1'b1;
            end
          end
          S_RESET, S_EOP_J: begin
            if (cnt == '0) begin
              state <= S_IDLE;
              txe   <= 1'b0;
              txdp  <= 1'b0;
              txdn  <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_RESUME: begin
            if (cnt == '0) begin
              state <= S_EOP_SE0;
              cnt   <= SE0_LOAD;
              txdp  <= 1'b0;
              txdn  <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_EOP_SE0: begin
            if (cnt == '0) begin
              state <= S_EOP_J;
              cnt   <= J_LOAD;
              txdp  <= ~lsp;
              txdn  <= lsp;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
            txe   <= 1'b0;
            txdp  <= 1'b0;
            txdn  <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_port_sig_tx.sv
`timescale 1ns/1ps
// Scoreboarded bench for usb_port_sig_tx: each request pushes its expected
// per-cycle line trace, a negedge monitor pops and compares every cycle.
module tb_usb_port_sig_tx;

  localparam int RST_CYC  = 20;
  localparam int RESM_CYC = 30;
  localparam int EOP_BIT  = 2;

  logic clk_12m = 1'b0;
  logic rst, start_rst, start_resm, sofgen, lsdev, enable;
  logic txe, txdp, txdn, busy, done;

  usb_port_sig_tx #(
    .RST_CYC (RST_CYC),
    .RESM_CYC(RESM_CYC),
    .EOP_BIT (EOP_BIT)
  ) dut (
    .clk_12m   (clk_12m),
    .rst       (rst),
    .start_rst (start_rst),
    .start_resm(start_resm),
    .sofgen    (sofgen),
    .lsdev     (lsdev),
    .enable    (enable),
    .txe       (txe),
    .txdp      (txdp),
    .txdn      (txdn),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_12m = ~clk_12m;

  // sample = {txe, txdp, txdn, busy, done}
  typedef logic [4:0] smp_t;
  smp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  smp_t act_s, exp_s;

  task automatic check(input string name, input smp_t act, input smp_t req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @%0t: got txe/dp/dn/busy/done=%b required %b", name, $time, act, req);
    end
  endtask

  // Reference model: sequences described as run lengths of line states.
  function automatic void push_n(input int n, input logic dp, input logic dn);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, dp, dn, 1'b1, 1'b0});
  endfunction

  function automatic void push_done();
    exp_q.push_back(5'b00001);
  endfunction

  function automatic void exp_reset();
    push_n(RST_CYC, 1'b0, 1'b0);
    push_done();
  endfunction

  // J for full speed is DP=1/DN=0, for low speed DP=0/DN=1; K is the opposite.
  function automatic void exp_eop(input logic ls);
    push_n(2 * EOP_BIT, 1'b0, 1'b0);
    push_n(EOP_BIT, ~ls, ls);
    push_done();
  endfunction

  function automatic void exp_resume(input logic ls);
    push_n(RESM_CYC, ls, ~ls);
    exp_eop(ls);
  endfunction

  always @(negedge clk_12m) begin
    if (!rst) begin
      act_s = {txe, txdp, txdn, busy, done};
      if (exp_q.size() != 0) begin
        exp_s = exp_q.pop_front();
        check("line", act_s, exp_s);
      end else if (act_s != 5'b0) begin
        check("spurious", act_s, 5'b0);
      end
    end
  end

  task automatic step();
    @(negedge clk_12m);
    #1;
  endtask

  task automatic pulse(input logic rs, input logic rm, input logic sof);
    start_rst  = rs;
    start_resm = rm;
    sofgen     = sof;
    step();
    start_rst  = 1'b0;
    start_resm = 1'b0;
    sofgen     = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      step();
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_%s: %0d samples still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, extra, mid, len;
    logic ls;
    rst = 1'b1; start_rst = 1'b0; start_resm = 1'b0; sofgen = 1'b0;
    lsdev = 1'b0; enable = 1'b0;
    repeat (3) step();
    check("reset_hold", {txe, txdp, txdn, busy, done}, 5'b0);
    rst = 1'b0;
    step();
    check("reset_state", {txe, txdp, txdn, busy, done}, 5'b0);

    // Port reset from idle
    exp_reset();
    pulse(1'b1, 1'b0, 1'b0);
    drain("reset");

    // Full-speed resume
    lsdev = 1'b0;
    exp_resume(1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    drain("resume_fs");

    // Low-speed keep-alive, then the same strobe with the port disabled
    enable = 1'b1; lsdev = 1'b1;
    exp_eop(1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    drain("keepalive");
    enable = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    repeat (10) step();

    // Reset wins over a simultaneous resume
    exp_reset();
    pulse(1'b1, 1'b1, 1'b0);
    drain("rst_priority");

    // Reset aborts a resume at its tenth cycle
    lsdev = 1'b0;
    exp_resume(1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (9) step();
    exp_q.delete();
    exp_reset();
    pulse(1'b1, 1'b0, 1'b0);
    drain("abort_resume");

    // Second reset request during reset does not restart the count
    exp_reset();
    pulse(1'b1, 1'b0, 1'b0);
    repeat (5) step();
    pulse(1'b1, 1'b0, 1'b0);
    drain("rst_no_restart");

    // Asynchronous reset during keep-alive SE0
    enable = 1'b1; lsdev = 1'b1;
    exp_eop(1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    step();
    #2 rst = 1'b1;
    #1 check("async_rst", {txe, txdp, txdn, busy, done}, 5'b0);
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    step();
    exp_eop(1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    drain("after_rst");

    // Latched polarity survives LSDEV toggling; strobes during busy are dropped
    lsdev = 1'b1;
    exp_resume(1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (4) step();
    lsdev = 1'b0;
    repeat (5) step();
    lsdev = 1'b1;
    pulse(1'b0, 1'b1, 1'b1);
    drain("latched_lsp");

    // Request accepted in the DONE cycle
    exp_eop(1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    drain("chain_a");
    exp_reset();
    pulse(1'b1, 1'b0, 1'b0);
    drain("chain_b");

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) step();
      kind = int'($urandom_range(0, 3));
      ls   = 1'b1;
      len  = 0;
      case (kind)
        0: begin
          lsdev = 1'($urandom_range(0, 1));
          exp_reset();
          len = RST_CYC;
          pulse(1'b1, 1'b0, 1'b0);
        end
        1: begin
          ls = 1'($urandom_range(0, 1));
          lsdev = ls;
          enable = 1'($urandom_range(0, 1));
          exp_resume(ls);
          len = RESM_CYC + 3 * EOP_BIT;
          pulse(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        end
        2: begin
          enable = 1'b1; lsdev = 1'b1;
          exp_eop(1'b1);
          len = 3 * EOP_BIT;
          pulse(1'b0, 1'b0, 1'b1);
        end
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            enable = 1'b0; lsdev = 1'($urandom_range(0, 1));
          end else begin
            enable = 1'b1; lsdev = 1'b0;
          end
          pulse(1'b0, 1'b0, 1'b1);
          repeat (4) step();
        end
      endcase
      if (len > 0) begin
        extra = int'($urandom_range(0, len - 1));
        mid   = int'($urandom_range(0, 3));
        repeat (extra) step();
        case (mid)
          1: begin
            enable = 1'b1; lsdev = 1'b1;
            pulse(1'b0, 1'b1, 1'b1);
          end
          2: lsdev = ~lsdev;
          3: begin
            if (kind != 0) begin
              exp_q.delete();
              exp_reset();
            end
            pulse(1'b1, 1'b0, 1'b0);
          end
          default: ;
        endcase
        drain("random");
      end
    end

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
